// File: rtl/deferred_assert_stim.sv
// deferred_assert_stim: LFSR-driven a/b stimulus for a deferred-assertion checker
// that registers b into c and asserts !(a & c). a is masked by the registered b,
// so the property holds by construction. Also mirrors c and keeps saturating
// activity/violation counters for cross-checking.
// Optional build macro FAULT_INJECT_EN adds inj_req, which forces one violation.
module deferred_assert_stim #(
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
  parameter int unsigned       NUM_CYCLES = 256,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  len,
`ifdef FAULT_INJECT_EN
  input  logic              inj_req,
`endif
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam logic [LFSR_W-1:0] POLY = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_nx;
  logic [CNT_W-1:0]   remaining;
  logic               c_mir;
  logic               fire;

  // Galois right-shift step of the stimulus LFSR
  always_comb begin
    lfsr_nx = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? POLY : '0);
  end

`ifdef FAULT_INJECT_EN
  logic armed;

  // One-shot injection: armed by inj_req in RUN, fires on the next RUN cycle with b high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (state_q == IDLE && start) begin
      armed <= 1'b0;
    end else if (fire) begin
      armed <= 1'b0;
    end else if (state_q == RUN && inj_req) begin
      armed <= 1'b1;
    end
  end

  // Mask bypass request for the current RUN cycle
  always_comb begin
    fire = (state_q == RUN) && armed && b;
  end
`else
  assign fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (remaining == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stimulus datapath: seed load, run length, LFSR stepping and a/b generation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      a         <= 1'b0;
      b         <= 1'b0;
      c_mir     <= 1'b0;
      remaining <= '0;
    end else begin
      c_mir <= b;
      case (state_q)
        IDLE: begin
          if (seed_ld) lfsr <= (seed == '0) ? SEED : seed;
          if (start)   remaining <= (len == '0) ? CNT_W'(NUM_CYCLES) : len;
        end
        RUN: begin
          // a/b come from the pre-step LFSR value; the mask uses the current b (next c)
          lfsr      <= lfsr_nx;
          b         <= lfsr[1];
          a         <= (lfsr[0] & ~b) | fire;
          remaining <= remaining - CNT_W'(1);
        end
        default: begin
          a <= 1'b0;
          b <= 1'b0;
        end
      endcase
    end
  end

  // Saturating activity and violation counters, cleared on an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cnt    <= '0;
      b_cnt    <= '0;
      viol_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      a_cnt    <= '0;
      b_cnt    <= '0;
      viol_cnt <= '0;
    end else if (busy) begin
      if (a && a_cnt != '1)             a_cnt    <= a_cnt + CNT_W'(1);
      if (b && b_cnt != '1)             b_cnt    <= b_cnt + CNT_W'(1);
      if (a && c_mir && viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_deferred_assert_stim.sv
// Testbench for deferred_assert_stim: directed runs with hand-computed LFSR heads
// and an independent sequence model for long runs.
module tb_deferred_assert_stim;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        seed_ld;
  logic [15:0] seed;
  logic [15:0] len;
`ifdef FAULT_INJECT_EN
  logic        inj_req;
`endif
  logic        a, b, busy, done;
  logic [15:0] a_cnt, b_cnt, viol_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed first 10 driven values from seed 16'hACE1 (bit0 = first cycle)
  logic [9:0] head_a;
  logic [9:0] head_b;

  // Observations and model expectations, indexed by cycle after start
  logic ea [0:1099];
  logic eb [0:1099];
  logic a_obs [0:1099];
  logic b_obs [0:1099];
  int   exp_acnt, exp_bcnt;

  int          busy_cycles, done_pulses, done_at, prop_err, cmir_err, seq_err;
  logic [15:0] acnt_done, bcnt_done, vcnt_done;
  logic [15:0] snap_acnt, snap_bcnt, snap_vcnt, snap_lfsr;
  logic        snap_a, snap_b, snap_busy;

  deferred_assert_stim #(
    .LFSR_W(16), .SEED(16'hACE1), .NUM_CYCLES(256), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_ld(seed_ld), .seed(seed), .len(len),
`ifdef FAULT_INJECT_EN
    .inj_req(inj_req),
`endif
    .a(a), .b(b), .busy(busy), .done(done),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .viol_cnt(viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference sequence: a/b of driven cycle k appear at observed cycle k+1
  task automatic build_exp(input logic [15:0] s, input int n);
    logic [15:0] l;
    logic bp, bk, ak;
    l = s; bp = 1'b0; exp_acnt = 0; exp_bcnt = 0;
    for (int i = 0; i < 1100; i++) begin ea[i] = 1'b0; eb[i] = 1'b0; end
    for (int k = 1; k <= n; k++) begin
      bk = l[1];
      ak = l[0] & ~bp;
      ea[k+1] = ak; eb[k+1] = bk;
      exp_acnt += int'(ak); exp_bcnt += int'(bk);
      l  = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      bp = bk;
    end
  endtask

  // Start a run at the current negedge and observe `watch` cycles, optionally
  // disturbing it with start/seed_ld, a reset pulse or an injection request
  task automatic do_run(input logic [15:0] l, input logic ld, input logic [15:0] sd,
                        input int watch, input int dist_at, input int rst_at, input int inj_at);
    busy_cycles = 0; done_pulses = 0; done_at = -1; prop_err = 0; cmir_err = 0; seq_err = 0;
    a_obs[0] = a; b_obs[0] = b;
    start = 1'b1; len = l; seed_ld = ld; seed = sd;
    for (int cyc = 1; cyc <= watch; cyc++) begin
      @(negedge clk);
      a_obs[cyc] = a; b_obs[cyc] = b;
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_at < 0) begin
          done_at = cyc; acnt_done = a_cnt; bcnt_done = b_cnt; vcnt_done = viol_cnt;
        end
      end
      if (cyc != rst_at + 1 && dut.c_mir !== b_obs[cyc-1]) cmir_err++;
      if (b_obs[cyc-1] && a_obs[cyc]) prop_err++;
      if (a_obs[cyc] !== ea[cyc] || b_obs[cyc] !== eb[cyc]) seq_err++;
      if (cyc == rst_at + 1) begin
        snap_a = a; snap_b = b; snap_busy = busy;
        snap_acnt = a_cnt; snap_bcnt = b_cnt; snap_vcnt = viol_cnt; snap_lfsr = dut.lfsr;
      end
      start   = (cyc == dist_at);
      seed_ld = (cyc == dist_at);
      if (cyc == dist_at) begin len = 16'd2; seed = 16'h1234; end
      rst_n   = !(cyc == rst_at);
`ifdef FAULT_INJECT_EN
      inj_req = (cyc == inj_at);
`endif
    end
  endtask

  task automatic load_default_seed();
    seed_ld = 1'b1; seed = 16'h0000;
    @(negedge clk);
    seed_ld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] ga, gb;
    head_a = 10'b0000000001;
    head_b = 10'b1001110000;
    rst_n = 1'b0; start = 1'b0; seed_ld = 1'b0; seed = '0; len = '0;
`ifdef FAULT_INJECT_EN
    inj_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_viol_cnt", viol_cnt, 0);
    check("rst_lfsr", dut.lfsr, 16'hACE1);

    // Default length run from reset seed
    build_exp(16'hACE1, 256);
    do_run(16'd0, 1'b0, 16'h0, 270, -1, -1, -1);
    for (int k = 0; k < 10; k++) begin ga[k] = a_obs[k+2]; gb[k] = b_obs[k+2]; end
    check("def_head_a", {22'd0, ga}, {22'd0, head_a});
    check("def_head_b", {22'd0, gb}, {22'd0, head_b});
    check("def_busy_cycles", busy_cycles, 257);
    check("def_done_pulses", done_pulses, 1);
    check("def_done_at", done_at, 258);
    check("def_a_cnt", acnt_done, exp_acnt);
    check("def_b_cnt", bcnt_done, exp_bcnt);
    check("def_a_cnt_nonzero", acnt_done != 0, 1);
    check("def_b_cnt_nonzero", bcnt_done != 0, 1);
    check("def_viol_cnt", vcnt_done, 0);
    check("def_seq", seq_err, 0);
    check("def_prop", prop_err, 0);
    check("def_cmir", cmir_err, 0);
    check("def_cnt_hold", a_cnt, acnt_done);

    // Zero seed load selects SEED; len=8
    load_default_seed();
    build_exp(16'hACE1, 8);
    do_run(16'd8, 1'b0, 16'h0, 16, -1, -1, -1);
    for (int k = 0; k < 10; k++) begin ga[k] = a_obs[k+2]; gb[k] = b_obs[k+2]; end
    check("len8_head_a", {24'd0, ga[7:0]}, {24'd0, head_a[7:0]});
    check("len8_head_b", {24'd0, gb[7:0]}, {24'd0, head_b[7:0]});
    check("len8_done_at", done_at, 10);
    check("len8_busy_cycles", busy_cycles, 9);
    check("len8_a_cnt", acnt_done, 1);
    check("len8_b_cnt", bcnt_done, 3);
    check("len8_seq", seq_err, 0);

    // Long run, seed loaded in the same cycle as start
    build_exp(16'h5A5A, 1000);
    do_run(16'd1000, 1'b1, 16'h5A5A, 1008, -1, -1, -1);
    check("long_seq", seq_err, 0);
    check("long_prop", prop_err, 0);
    check("long_cmir", cmir_err, 0);
    check("long_busy_cycles", busy_cycles, 1001);
    check("long_a_cnt", acnt_done, exp_acnt);
    check("long_b_cnt", bcnt_done, exp_bcnt);
    check("long_viol_cnt", vcnt_done, 0);

    // Reset in cycle 5 of a len=20 run
    load_default_seed();
    build_exp(16'hACE1, 4);
    do_run(16'd20, 1'b0, 16'h0, 40, -1, 5, -1);
    check("abort_a", snap_a, 0);
    check("abort_b", snap_b, 0);
    check("abort_busy", snap_busy, 0);
    check("abort_a_cnt", snap_acnt, 0);
    check("abort_b_cnt", snap_bcnt, 0);
    check("abort_viol_cnt", snap_vcnt, 0);
    check("abort_lfsr", snap_lfsr, 16'hACE1);
    check("abort_done_pulses", done_pulses, 0);

    // start and seed_ld while busy are ignored
    load_default_seed();
    build_exp(16'hACE1, 8);
    do_run(16'd8, 1'b0, 16'h0, 20, 3, -1, -1);
    check("busy_ign_seq", seq_err, 0);
    check("busy_ign_busy_cycles", busy_cycles, 9);
    check("busy_ign_done_pulses", done_pulses, 1);
    check("busy_ign_done_at", done_at, 10);

    // Minimum length
    load_default_seed();
    build_exp(16'hACE1, 1);
    do_run(16'd1, 1'b0, 16'h0, 8, -1, -1, -1);
    check("len1_done_at", done_at, 3);
    check("len1_busy_cycles", busy_cycles, 2);
    check("len1_a_first", a_obs[2], 1);
    check("len1_a_cnt", acnt_done, 1);

`ifdef FAULT_INJECT_EN
    // Injected violation: exactly one a & c event
    load_default_seed();
    build_exp(16'hACE1, 64);
    do_run(16'd64, 1'b0, 16'h0, 72, -1, -1, 3);
    check("inj_viol_cnt", vcnt_done, 1);
    check("inj_prop", prop_err, 1);
    check("inj_done_pulses", done_pulses, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
